fpu_result_sink: RTL and testbench

Consumer end of the FPU output handshake. It accepts results and status through an out_valid/out_ready interface, with an optional deterministic backpressure pattern, and buffers them in a small FIFO. It folds each result into a rotate-XOR signature, ORs the status flags together, and raises done_o after a programmed number of results. Testbenches instantiate it opposite the operand generator to close the loop and stop simulation. It is synthesizable, so it can also be used in FPGA bring-up.

---
 rtl/fpu_sink_pkg.sv | 20 ++
 rtl/fpu_sink_fifo.sv | 59 +++++
 rtl/fpu_result_sink.sv | 140 ++++++++++++++
 tb/tb_fpu_result_sink.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_sink_pkg.sv
// Shared types for the FPU result sink: run states, FIFO entry layout, status width.
package fpu_sink_pkg;

  localparam int STATUS_W = 5;
  localparam int RESULT_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } sink_state_e;

  typedef struct packed {
    logic [RESULT_W-1:0] result;
    logic [STATUS_W-1:0] status;
    logic                tag;
  } sink_entry_t;

endpackage

// File: rtl/fpu_sink_fifo.sv
// Generic DEPTH-entry synchronous FIFO; read data is the current head (show-ahead).
module fpu_sink_fifo #(
  parameter int DATA_W = 22,
  parameter int DEPTH  = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              push_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] data_o,
  output logic              full_o,
  output logic              empty_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [PTR_W:0]   FILL_ONE = (PTR_W + 1)'(1);
  localparam logic [PTR_W:0]   FILL_MAX = (PTR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [PTR_W:0]    fill_r;
  logic              push_ok_s;
  logic              pop_ok_s;

  assign full_o    = (fill_r == FILL_MAX);
  assign empty_o   = (fill_r == {(PTR_W + 1){1'b0}});
  assign push_ok_s = push_i && !full_o;
  assign pop_ok_s  = pop_i && !empty_o;
  assign data_o    = mem_r[rd_ptr_r];

  // Storage, wrapping pointers and fill level.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      fill_r   <= {(PTR_W + 1){1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {DATA_W{1'b0}};
      end
    end else begin
      if (push_ok_s) begin
        mem_r[wr_ptr_r] <= data_i;
        wr_ptr_r        <= wr_ptr_r + PTR_ONE;
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   fill_r <= fill_r + FILL_ONE;
        2'b01:   fill_r <= fill_r - FILL_ONE;
        default: fill_r <= fill_r;
      endcase
    end
  end

endmodule

// File: rtl/fpu_result_sink.sv
// Consumer end of the FPU output handshake: buffers results, folds them into a
// rotate-XOR signature, ORs status flags and flags completion after NUM_RESULTS.
module fpu_result_sink
  import fpu_sink_pkg::*;
#(
  parameter int         WIDTH       = RESULT_W,
  parameter int         DEPTH       = 4,
  parameter int         NUM_RESULTS = 16,
  parameter logic [7:0] STALL_MASK  = 8'hDB
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [WIDTH-1:0]    result_i,
  input  logic [STATUS_W-1:0] status_i,
  input  logic                tag_i,
  input  logic                out_valid_i,
  output logic                out_ready_o,
  input  logic                stall_en_i,
  input  logic                start_i,
  output logic [15:0]         count_o,
  output logic [WIDTH-1:0]    signature_o,
  output logic [STATUS_W-1:0] status_acc_o,
  output logic                done_o
);

  localparam logic [15:0] LAST_CNT = 16'(NUM_RESULTS - 1);

  sink_state_e         state_r;
  sink_state_e         state_nxt_s;
  logic [7:0]          mask_r;
  logic [15:0]         count_r;
  logic [WIDTH-1:0]    sig_r;
  logic [STATUS_W-1:0] acc_r;
  logic                done_r;
  sink_entry_t         push_entry_s;
  sink_entry_t         pop_entry_s;
  logic                fifo_full_s;
  logic                fifo_empty_s;
  logic                handshake_s;
  logic                pop_s;
  logic                start_ok_s;
  logic                unused_tag_s;

  function automatic logic [WIDTH-1:0] sig_fold(input logic [WIDTH-1:0] sig,
                                                input logic [WIDTH-1:0] data);
    return {sig[WIDTH-2:0], sig[WIDTH-1]} ^ data;
  endfunction

  // Ready depends only on registered state plus the static stall enable.
  assign out_ready_o  = (state_r == ST_RUN) && !fifo_full_s && (!stall_en_i || mask_r[0]);
  assign handshake_s  = out_valid_i && out_ready_o;
  assign pop_s        = !fifo_empty_s;
  assign start_ok_s   = start_i && ((state_r == ST_IDLE) || (state_r == ST_DONE));
  assign unused_tag_s = pop_entry_s.tag;

  assign push_entry_s.result = result_i;
  assign push_entry_s.status = status_i;
  assign push_entry_s.tag    = tag_i;

  fpu_sink_fifo #(
    .DATA_W ($bits(sink_entry_t)),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (handshake_s),
    .data_i  (push_entry_s),
    .pop_i   (pop_s),
    .data_o  (pop_entry_s),
    .full_o  (fifo_full_s),
    .empty_o (fifo_empty_s)
  );

  // Run sequencing: start, quota reached, drained.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start_i) state_nxt_s = ST_RUN;
        else         state_nxt_s = ST_IDLE;
      end
      ST_RUN: begin
        if (handshake_s && (count_r == LAST_CNT)) state_nxt_s = ST_DRAIN;
        else                                      state_nxt_s = ST_RUN;
      end
      ST_DRAIN: begin
        if (fifo_empty_s) state_nxt_s = ST_DONE;
        else              state_nxt_s = ST_DRAIN;
      end
      ST_DONE: begin
        if (start_i) state_nxt_s = ST_RUN;
        else         state_nxt_s = ST_DONE;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State register with a registered copy of the DONE decode.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r <= ST_IDLE;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      done_r  <= (state_nxt_s == ST_DONE);
    end
  end

  // Mask rotation, handshake count, signature and status accumulation.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mask_r  <= STALL_MASK;
      count_r <= 16'd0;
      sig_r   <= {WIDTH{1'b0}};
      acc_r   <= {STATUS_W{1'b0}};
    end else if (start_ok_s) begin
      mask_r  <= STALL_MASK;
      count_r <= 16'd0;
      sig_r   <= {WIDTH{1'b0}};
      acc_r   <= {STATUS_W{1'b0}};
    end else begin
      if (state_r == ST_RUN) begin
        mask_r <= {mask_r[0], mask_r[7:1]};
      end
      if (handshake_s) begin
        count_r <= count_r + 16'd1;
      end
      if (pop_s) begin
        sig_r <= sig_fold(sig_r, pop_entry_s.result);
        acc_r <= acc_r | pop_entry_s.status;
      end
    end
  end

  assign count_o      = count_r;
  assign signature_o  = sig_r;
  assign status_acc_o = acc_r;
  assign done_o       = done_r;

endmodule

// File: tb/tb_fpu_result_sink.sv
// Directed bench for fpu_result_sink: a queue-based reference model checked every
// cycle, plus hand-computed literal expectations for the key scenarios.
module tb_fpu_result_sink;

  localparam int         W  = 16;
  localparam int         D  = 4;
  localparam int         N  = 6;
  localparam logic [7:0] SM = 8'hDB;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [W-1:0]  result = '0;
  logic [4:0]    status = '0;
  logic          tag = 1'b0;
  logic          out_valid = 1'b0;
  logic          out_ready;
  logic          stall_en = 1'b0;
  logic          start = 1'b0;
  logic [15:0]   count;
  logic [W-1:0]  sig;
  logic [4:0]    acc;
  logic          done;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  fpu_result_sink #(
    .WIDTH(W), .DEPTH(D), .NUM_RESULTS(N), .STALL_MASK(SM)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .result_i(result), .status_i(status), .tag_i(tag),
    .out_valid_i(out_valid), .out_ready_o(out_ready), .stall_en_i(stall_en),
    .start_i(start), .count_o(count), .signature_o(sig), .status_acc_o(acc), .done_o(done)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: phase 0 idle, 1 accepting, 2 draining, 3 finished.
  int          m_phase;
  int          m_cnt;
  int          m_runcyc;
  logic [15:0] m_sig;
  logic [4:0]  m_acc;
  logic [20:0] m_q[$];
  logic        m_hs;
  int          m_pre;
  logic [20:0] m_e;

  function automatic logic m_ready();
    return (m_phase == 1) && (m_q.size() < D) && (!stall_en || SM[m_runcyc % 8]);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = 0; m_cnt = 0; m_runcyc = 0; m_sig = '0; m_acc = '0;
      m_q.delete();
    end else begin
      m_hs  = out_valid && m_ready();
      m_pre = m_q.size();
      if (m_pre > 0) begin
        m_e   = m_q.pop_front();
        m_sig = ((m_sig << 1) | (m_sig >> 15)) ^ m_e[20:5];
        m_acc = m_acc | m_e[4:0];
      end
      if (m_hs) m_q.push_back({result, status});
      if ((m_phase == 0 || m_phase == 3) && start) begin
        m_phase = 1; m_cnt = 0; m_runcyc = 0; m_sig = '0; m_acc = '0;
      end else if (m_phase == 1) begin
        m_runcyc++;
        if (m_hs) begin
          m_cnt++;
          if (m_cnt == N) m_phase = 2;
        end
      end else if (m_phase == 2 && m_pre == 0) begin
        m_phase = 3;
      end
    end
  end

  // Compare process on the falling edge, away from DUT updates.
  always @(negedge clk) begin
    if (rst_n) begin
      check("ready", out_ready, m_ready());
      check("count", count, m_cnt);
      check("signature", sig, m_sig);
      check("status_acc", acc, m_acc);
      check("done", done, (m_phase == 3));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_pulse();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 20 && !done; i++) tick();
    check("wait_done", done, 1'b1);
  endtask

  logic [15:0] d1 [6] = '{16'h3C00, 16'h4000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
  logic [4:0]  s3 [6] = '{5'b00001, 5'b10000, 5'b00000, 5'b00000, 5'b00000, 5'b00000};
  logic [7:0]  rdy_bits;
  int          hs_n;

  initial begin
    #1 rst_n = 1'b0;
    #10;
    check("rst_ready", out_ready, 1'b0);
    check("rst_count", count, 16'd0);
    check("rst_sig", sig, 16'h0000);
    check("rst_acc", acc, 5'b00000);
    check("rst_done", done, 1'b0);
    @(posedge clk); #1 rst_n = 1'b1;
    tick();
    check("idle_ready", out_ready, 1'b0);

    // Basic signature, continuous valid, no stall.
    start_pulse();
    for (int i = 0; i < 6; i++) begin
      out_valid = 1'b1; result = d1[i]; status = 5'b00000;
      tick();
      if (i == 2) check("t1_sig_two", sig, 16'h3800);
    end
    out_valid = 1'b0;
    check("t1_count", count, 16'd6);
    check("t1_done_e0", done, 1'b0);
    tick();
    check("t1_done_e1", done, 1'b0);
    tick();
    check("t1_done_e2", done, 1'b1);
    check("t1_sig_final", sig, 16'h8003);

    // Backpressure through the rotating mask.
    stall_en = 1'b1; out_valid = 1'b1;
    start_pulse();
    for (int k = 0; k < 8; k++) begin
      rdy_bits[k] = out_ready;
      result = 16'h1000 + 16'(k);
      tick();
    end
    check("t2_pattern", rdy_bits, 8'hDB);
    check("t2_count", count, 16'd6);
    out_valid = 1'b0; stall_en = 1'b0;
    wait_done();

    // Status accumulation.
    start_pulse();
    for (int i = 0; i < 6; i++) begin
      out_valid = 1'b1; result = 16'h0101 * 16'(i + 1); status = s3[i];
      tick();
    end
    out_valid = 1'b0; status = 5'b00000;
    wait_done();
    check("t3_acc", acc, 5'b10001);

    // Termination with valid held high.
    out_valid = 1'b1;
    start_pulse();
    hs_n = 0;
    for (int k = 0; k < 20; k++) begin
      if (out_valid && out_ready) hs_n++;
      result = 16'hA000 + 16'(k);
      tick();
    end
    check("t4_handshakes", hs_n, 6);
    check("t4_count", count, 16'd6);
    check("t4_done", done, 1'b1);
    check("t4_ready_low", out_ready, 1'b0);

    // Restart from DONE with valid still high; start during RUN is ignored.
    start_pulse();
    check("t5_count_clr", count, 16'd0);
    check("t5_sig_clr", sig, 16'h0000);
    check("t5_acc_clr", acc, 5'b00000);
    check("t5_done_clr", done, 1'b0);
    for (int i = 0; i < 6; i++) begin
      result = d1[i];
      start = (i == 2);
      tick();
    end
    start = 1'b0; out_valid = 1'b0;
    wait_done();
    check("t5_sig_repeat", sig, 16'h8003);
    check("t5_count", count, 16'd6);

    // Reset asserted during the second handshake.
    start_pulse();
    out_valid = 1'b1; result = 16'h1111;
    tick();
    result = 16'h2222;
    #2 rst_n = 1'b0;
    #1;
    check("t6_ready", out_ready, 1'b0);
    check("t6_count", count, 16'd0);
    check("t6_sig", sig, 16'h0000);
    check("t6_acc", acc, 5'b00000);
    check("t6_done", done, 1'b0);
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("t6_idle_ready", out_ready, 1'b0);
    end
    start_pulse();
    check("t6_restart_ready", out_ready, 1'b1);
    for (int i = 0; i < 6; i++) begin
      result = d1[i];
      tick();
    end
    out_valid = 1'b0;
    wait_done();
    check("t6_sig_final", sig, 16'h8003);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1, "watchdog");
  end

endmodule
